pad_rx_capture: RTL

//  Input-side companion to the core's per-side pad drive (dout/oen/ie).

---
 rtl/pad_rx_pkg.sv | 10 +
 rtl/pad_rx_capture_if.sv | 25 ++
 rtl/pad_rx_debounce.sv | 66 ++++++
 rtl/pad_rx_capture.sv | 66 ++++++
 4 files changed

// File: rtl/pad_rx_pkg.sv
// Shared pin-count and debounce-width constants plus vector types for the pad receive capture block.
package pad_rx_pkg;

  localparam int PAD_NPINS = 9;
  localparam int PAD_DBW   = 8;

  typedef logic [PAD_NPINS-1:0] pad_vec_t;
  typedef logic [PAD_DBW-1:0]   pad_db_t;

endpackage

// File: rtl/pad_rx_capture_if.sv
// Control/status bundle for one padring side's receive capture: raw pins and config in, level/status/irq out.
interface pad_rx_capture_if;
  import pad_rx_pkg::*;

  pad_vec_t din;
  pad_vec_t ie;
  pad_db_t  db_limit;
  pad_vec_t rise_en;
  pad_vec_t fall_en;
  pad_vec_t clr;
  pad_vec_t value;
  pad_vec_t status;
  logic     irq;

  modport master (
    output din, ie, db_limit, rise_en, fall_en, clr,
    input  value, status, irq
  );

  modport slave (
    input  din, ie, db_limit, rise_en, fall_en, clr,
    output value, status, irq
  );

endinterface

// File: rtl/pad_rx_debounce.sv
// Single-pin debouncer: value follows s once s has differed for db_limit+1 consecutive cycles.
// PAD_RX_DEBOUNCE_EN selects the counting filter; otherwise value simply registers s every cycle.
module pad_rx_debounce
  import pad_rx_pkg::*;
#(
  parameter int DBW = PAD_DBW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_i,
  input  logic [DBW-1:0] db_limit_i,
  output logic           value_o,
  output logic           upd_o
);

  logic value_q, value_d;

`ifdef PAD_RX_DEBOUNCE_EN
  logic [DBW-1:0] cnt_q, cnt_d;

  // db_limit is compared live, so lowering it below an in-flight count commits on the next edge
  always_comb begin
    value_d = value_q;
    cnt_d   = cnt_q;
    upd_o   = 1'b0;
    if (s_i == value_q) begin
      cnt_d = '0;
    end else if (cnt_q >= db_limit_i) begin
      value_d = s_i;
      cnt_d   = '0;
      upd_o   = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_db_limit;
  assign unused_db_limit = ^db_limit_i;

  always_comb begin
    value_d = s_i;
    upd_o   = s_i ^ value_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 1'b0;
    end else begin
      value_q <= value_d;
    end
  end
`endif

  assign value_o = value_q;

endmodule

// File: rtl/pad_rx_capture.sv
// Per-side pad receive capture: sync + ie mask, per-pin debounce, W1C edge status and level irq.
// Debounce filtering is built only with PAD_RX_DEBOUNCE_EN; status/irq behave the same either way.
module pad_rx_capture
  import pad_rx_pkg::*;
#(
  parameter int NPINS       = PAD_NPINS,
  parameter int SYNC_STAGES = 2,
  parameter int DBW         = PAD_DBW
) (
  input  logic        clk,
  input  logic        rst,
  pad_rx_capture_if.slave bus
);

  logic [NPINS-1:0] sync_q [SYNC_STAGES];
  logic [NPINS-1:0] s;
  logic [NPINS-1:0] upd;
  logic [NPINS-1:0] value;
  logic [NPINS-1:0] rise;
  logic [NPINS-1:0] fall;
  logic [NPINS-1:0] status_d, status_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.din;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // ie is already in the clk domain, so masking after the synchronizer adds no latency
  assign s = sync_q[SYNC_STAGES-1] & bus.ie;

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    pad_rx_debounce #(.DBW(DBW)) u_db (
      .clk        (clk),
      .rst        (rst),
      .s_i        (s[i]),
      .db_limit_i (bus.db_limit),
      .value_o    (value[i]),
      .upd_o      (upd[i])
    );
  end

  assign rise = ~value & upd &  s;
  assign fall =  value & upd & ~s;

  // a new event outranks a same-cycle clear of the same bit
  always_comb begin
    status_d = (status_q & ~bus.clr) | (rise & bus.rise_en) | (fall & bus.fall_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign bus.value  = value;
  assign bus.status = status_q;
  assign bus.irq    = |status_q;

endmodule
